// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch front-end: lane geometry, FSM
// encoding, and the lane-mask / flat-bus packing helpers.
package fetch_pkg;

    localparam int FETCH_WIDTH = 4;
    localparam int PC_W        = 16;
    localparam int CNT_W       = 3;
    localparam int FREE_W      = 4;
    localparam int FLAT_W      = FETCH_WIDTH * PC_W;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STALL    = 2'd2,
        ST_REDIRECT = 2'd3
    } fetch_state_e;

    // Lane 0 occupies the most significant slice of the flat PC bus.
    function automatic int lane_lsb(input int lane);
        return PC_W * (FETCH_WIDTH - 1 - lane);
    endfunction

    function automatic logic [FETCH_WIDTH-1:0] cnt_to_mask(input logic [CNT_W-1:0] cnt);
        logic [FETCH_WIDTH-1:0] mask;
        case (cnt)
            3'd0:    mask = 4'b0000;
            3'd1:    mask = 4'b1000;
            3'd2:    mask = 4'b1100;
            3'd3:    mask = 4'b1110;
            3'd4:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/fetch_inflight_tracker.sv
// Two-stage in-flight pipeline (icache request, decode register) with squash,
// plus the free-slot budget that limits how many lanes may be requested.
module fetch_inflight_tracker
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              squash,
    input  logic [CNT_W-1:0]  issue_cnt,
    input  logic [PC_W-1:0]   issue_pc,
    input  logic [FREE_W-1:0] ibuf_free,
    output logic [FREE_W-1:0] avail,
    output logic              s2_valid,
    output logic [CNT_W-1:0]  s2_cnt,
    output logic [PC_W-1:0]   s2_pc
);

    logic             s1_valid_q, s1_valid_d;
    logic [CNT_W-1:0] s1_cnt_q,   s1_cnt_d;
    logic [PC_W-1:0]  s1_pc_q,    s1_pc_d;
    logic             s2_valid_q, s2_valid_d;
    logic [CNT_W-1:0] s2_cnt_q,   s2_cnt_d;
    logic [PC_W-1:0]  s2_pc_q,    s2_pc_d;

    logic signed [5:0] s1_load_s, s2_load_s, avail_raw_s;

    // Slots already promised to groups still in flight are not free yet.
    always_comb begin
        s1_load_s   = s1_valid_q ? $signed({3'b000, s1_cnt_q}) : 6'sd0;
        s2_load_s   = s2_valid_q ? $signed({3'b000, s2_cnt_q}) : 6'sd0;
        avail_raw_s = $signed({2'b00, ibuf_free}) - s1_load_s - s2_load_s;
        if (avail_raw_s < 6'sd0) begin
            avail = 4'd0;
        end else begin
            avail = avail_raw_s[3:0];
        end
    end

    // Advance the pipeline; a squash kills both stages at the same edge.
    always_comb begin
        s1_pc_d = issue_pc;
        s2_pc_d = s1_pc_q;
        if (squash) begin
            s1_valid_d = 1'b0;
            s1_cnt_d   = 3'd0;
            s2_valid_d = 1'b0;
            s2_cnt_d   = 3'd0;
        end else begin
            s1_valid_d = (issue_cnt != 3'd0);
            s1_cnt_d   = issue_cnt;
            s2_valid_d = s1_valid_q;
            s2_cnt_d   = s1_cnt_q;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_cnt_q   <= 3'd0;
            s1_pc_q    <= 16'h0000;
            s2_valid_q <= 1'b0;
            s2_cnt_q   <= 3'd0;
            s2_pc_q    <= 16'h0000;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_cnt_q   <= s1_cnt_d;
            s1_pc_q    <= s1_pc_d;
            s2_valid_q <= s2_valid_d;
            s2_cnt_q   <= s2_cnt_d;
            s2_pc_q    <= s2_pc_d;
        end
    end

    assign s2_valid = s2_valid_q;
    assign s2_cnt   = s2_cnt_q;
    assign s2_pc    = s2_pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch front-end controller: owns the fetch PC, decides lanes per cycle,
// handles branch redirects and presents decoded groups with lane masks.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic [FREE_W-1:0] ibuf_free,
    output logic              req_valid,
    output logic [CNT_W-1:0]  req_cnt,
    output logic [FLAT_W-1:0] pc_to_icache_flat,
    output logic              grp_valid,
    output logic [FETCH_WIDTH-1:0] grp_mask,
    output logic [PC_W-1:0]   grp_pc,
    output logic [1:0]        fsm_state
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;

    logic [CNT_W-1:0]  issue_cnt_s;
    logic [CNT_W-1:0]  clamp_cnt_s;
    logic              squash_s;
    logic [FREE_W-1:0] avail_s;
    logic              s2_valid_s;
    logic [CNT_W-1:0]  s2_cnt_s;
    logic [PC_W-1:0]   s2_pc_s;

    fetch_inflight_tracker u_tracker (
        .clk       (clk),
        .rst       (rst),
        .squash    (squash_s),
        .issue_cnt (issue_cnt_s),
        .issue_pc  (fetch_pc_q),
        .ibuf_free (ibuf_free),
        .avail     (avail_s),
        .s2_valid  (s2_valid_s),
        .s2_cnt    (s2_cnt_s),
        .s2_pc     (s2_pc_s)
    );

    // Next-state, issue count and PC advance; a redirect overrides every state.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        issue_cnt_s = 3'd0;
        squash_s    = 1'b0;
        clamp_cnt_s = (avail_s > 4'd4) ? 3'd4 : avail_s[2:0];
        if (redirect_valid) begin
            squash_s   = 1'b1;
            fetch_pc_d = {redirect_pc[PC_W-1:1], 1'b0};
            state_d    = ST_REDIRECT;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_d = ST_RUN;
                end
                ST_RUN, ST_STALL, ST_REDIRECT: begin
                    issue_cnt_s = clamp_cnt_s;
                    fetch_pc_d  = fetch_pc_q + {12'd0, clamp_cnt_s, 1'b0};
                    state_d     = (clamp_cnt_s == 3'd0) ? ST_STALL : ST_RUN;
                end
                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end
    end

    // FSM and fetch PC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Lane PCs are always presented, even past req_cnt, so the icache can prefetch.
    always_comb begin
        pc_to_icache_flat = {FLAT_W{1'b0}};
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            pc_to_icache_flat[lane_lsb(i) +: PC_W] = fetch_pc_q + 16'(2 * i);
        end
    end

    assign req_valid = (issue_cnt_s != 3'd0);
    assign req_cnt   = issue_cnt_s;
    assign grp_valid = s2_valid_s;
    assign grp_mask  = s2_valid_s ? cnt_to_mask(s2_cnt_s) : 4'b0000;
    assign grp_pc    = s2_pc_s;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [3:0]  ibuf_free = 4'd0;
    logic        req_valid;
    logic [2:0]  req_cnt;
    logic [63:0] pc_to_icache_flat;
    logic        grp_valid;
    logic [3:0]  grp_mask;
    logic [15:0] grp_pc;
    logic [1:0]  fsm_state;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rv;
        logic [15:0] rpc;
        logic [3:0]  free;
        logic        e_req;
        logic [2:0]  e_cnt;
        logic [15:0] e_pc;
        logic        e_gv;
        logic [3:0]  e_mask;
        logic [15:0] e_gpc;
        logic [1:0]  e_st;
    } vec_t;

    typedef struct {
        int cnt;
        int pc;
        int born;
    } grp_t;

    vec_t tbl[18];
    grp_t inflight[$];

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(16'h0000)) dut (
        .clk               (clk),
        .rst               (rst),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .ibuf_free         (ibuf_free),
        .req_valid         (req_valid),
        .req_cnt           (req_cnt),
        .pc_to_icache_flat (pc_to_icache_flat),
        .grp_valid         (grp_valid),
        .grp_mask          (grp_mask),
        .grp_pc            (grp_pc),
        .fsm_state         (fsm_state)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] mk_flat(input logic [15:0] p);
        logic [15:0] a, b, c;
        a = p + 16'd2;
        b = p + 16'd4;
        c = p + 16'd6;
        return {p, a, b, c};
    endfunction

    task automatic drive(input logic rv, input logic [15:0] rpc, input logic [3:0] fr);
        redirect_valid = rv;
        redirect_pc    = rpc;
        ibuf_free      = fr;
        #1;
    endtask

    task automatic check_all(input string tag, input logic e_req, input logic [2:0] e_cnt,
                             input logic [15:0] e_pc, input logic e_gv, input logic [3:0] e_mask,
                             input logic [15:0] e_gpc, input logic [1:0] e_st);
        check({tag, ".req_valid"}, 64'(req_valid), 64'(e_req));
        check({tag, ".req_cnt"},   64'(req_cnt),   64'(e_cnt));
        check({tag, ".flat"},      pc_to_icache_flat, mk_flat(e_pc));
        check({tag, ".grp_valid"}, 64'(grp_valid), 64'(e_gv));
        check({tag, ".grp_mask"},  64'(grp_mask),  64'(e_mask));
        if (e_gv) begin
            check({tag, ".grp_pc"}, 64'(grp_pc), 64'(e_gpc));
        end
        check({tag, ".state"},     64'(fsm_state), 64'(e_st));
    endtask

    // Leaves the bench at a negedge with rst just released (first BOOT cycle).
    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0000;
        ibuf_free = 4'd15;
        @(posedge clk);
        @(negedge clk);
        #1;
        check_all("rst_hold", 1'b0, 3'd0, 16'h0000, 1'b0, 4'b0000, 16'h0000, 2'd0);
        check("rst_hold.grp_pc", 64'(grp_pc), 64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 16'h0000, 4'd15, 1'b0, 3'd0, 16'h0000, 1'b0, 4'h0, 16'h0000, 2'd0};
        tbl[1]  = '{1'b0, 16'h0000, 4'd15, 1'b1, 3'd4, 16'h0000, 1'b0, 4'h0, 16'h0000, 2'd1};
        tbl[2]  = '{1'b0, 16'h0000, 4'd15, 1'b1, 3'd4, 16'h0008, 1'b0, 4'h0, 16'h0000, 2'd1};
        tbl[3]  = '{1'b0, 16'h0000, 4'd15, 1'b1, 3'd4, 16'h0010, 1'b1, 4'hF, 16'h0000, 2'd1};
        tbl[4]  = '{1'b1, 16'h0041, 4'd15, 1'b0, 3'd0, 16'h0018, 1'b1, 4'hF, 16'h0008, 2'd1};
        tbl[5]  = '{1'b0, 16'h0000, 4'd15, 1'b1, 3'd4, 16'h0040, 1'b0, 4'h0, 16'h0000, 2'd3};
        tbl[6]  = '{1'b0, 16'h0000, 4'd15, 1'b1, 3'd4, 16'h0048, 1'b0, 4'h0, 16'h0000, 2'd1};
        tbl[7]  = '{1'b0, 16'h0000, 4'd15, 1'b1, 3'd4, 16'h0050, 1'b1, 4'hF, 16'h0040, 2'd1};
        tbl[8]  = '{1'b1, 16'h0101, 4'd0,  1'b0, 3'd0, 16'h0058, 1'b1, 4'hF, 16'h0048, 2'd1};
        tbl[9]  = '{1'b0, 16'h0000, 4'd0,  1'b0, 3'd0, 16'h0100, 1'b0, 4'h0, 16'h0000, 2'd3};
        tbl[10] = '{1'b0, 16'h0000, 4'd0,  1'b0, 3'd0, 16'h0100, 1'b0, 4'h0, 16'h0000, 2'd2};
        tbl[11] = '{1'b0, 16'h0000, 4'd3,  1'b1, 3'd3, 16'h0100, 1'b0, 4'h0, 16'h0000, 2'd2};
        tbl[12] = '{1'b0, 16'h0000, 4'd0,  1'b0, 3'd0, 16'h0106, 1'b0, 4'h0, 16'h0000, 2'd1};
        tbl[13] = '{1'b0, 16'h0000, 4'd0,  1'b0, 3'd0, 16'h0106, 1'b1, 4'hE, 16'h0100, 2'd2};
        tbl[14] = '{1'b1, 16'hFFFC, 4'd15, 1'b0, 3'd0, 16'h0106, 1'b0, 4'h0, 16'h0000, 2'd2};
        tbl[15] = '{1'b0, 16'h0000, 4'd15, 1'b1, 3'd4, 16'hFFFC, 1'b0, 4'h0, 16'h0000, 2'd3};
        tbl[16] = '{1'b0, 16'h0000, 4'd15, 1'b1, 3'd4, 16'h0004, 1'b0, 4'h0, 16'h0000, 2'd1};
        tbl[17] = '{1'b0, 16'h0000, 4'd15, 1'b1, 3'd4, 16'h000C, 1'b1, 4'hF, 16'hFFFC, 2'd1};

        // Directed table: boot, steady fetch, redirect, redirect into stall, wrap.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].rv, tbl[i].rpc, tbl[i].free);
            check_all($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_cnt, tbl[i].e_pc,
                      tbl[i].e_gv, tbl[i].e_mask, tbl[i].e_gpc, tbl[i].e_st);
            @(negedge clk);
        end

        // Buffer not draining: 4, 2, 0 then stall until space opens up.
        do_reset();
        drive(1'b0, 16'h0000, 4'd6);  check("ib.c1.cnt", 64'(req_cnt), 64'd0);
        @(negedge clk);
        drive(1'b0, 16'h0000, 4'd6);  check("ib.c2.cnt", 64'(req_cnt), 64'd4);
        @(negedge clk);
        drive(1'b0, 16'h0000, 4'd6);  check("ib.c3.cnt", 64'(req_cnt), 64'd2);
        @(negedge clk);
        drive(1'b0, 16'h0000, 4'd6);  check("ib.c4.cnt", 64'(req_cnt), 64'd0);
        check("ib.c4.req", 64'(req_valid), 64'd0);
        @(negedge clk);
        drive(1'b0, 16'h0000, 4'd2);  check("ib.c5.st", 64'(fsm_state), 64'd2);
        check("ib.c5.req", 64'(req_valid), 64'd0);
        @(negedge clk);
        drive(1'b0, 16'h0000, 4'd0);  check("ib.c6.st", 64'(fsm_state), 64'd2);
        check("ib.c6.req", 64'(req_valid), 64'd0);
        @(negedge clk);
        drive(1'b0, 16'h0000, 4'd10); check("ib.c7.cnt", 64'(req_cnt), 64'd4);
        check("ib.c7.pc", pc_to_icache_flat, mk_flat(16'h000C));
        @(negedge clk);
        drive(1'b0, 16'h0000, 4'd15); check("ib.c8.st", 64'(fsm_state), 64'd1);
        @(negedge clk);
        drive(1'b0, 16'h0000, 4'd15); check("ib.c9.gv", 64'(grp_valid), 64'd1);

        // Asynchronous reset mid-cycle with both stages occupied.
        #2;
        rst = 1'b1;
        #1;
        check_all("arst", 1'b0, 3'd0, 16'h0000, 1'b0, 4'b0000, 16'h0000, 2'd0);
        check("arst.grp_pc", 64'(grp_pc), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 16'h0000, 4'd15);
        check_all("rs1", 1'b0, 3'd0, 16'h0000, 1'b0, 4'h0, 16'h0000, 2'd0);
        @(negedge clk);
        drive(1'b0, 16'h0000, 4'd15);
        check_all("rs2", 1'b1, 3'd4, 16'h0000, 1'b0, 4'h0, 16'h0000, 2'd1);
        @(negedge clk);
        drive(1'b0, 16'h0000, 4'd15);
        check_all("rs3", 1'b1, 3'd4, 16'h0008, 1'b0, 4'h0, 16'h0000, 2'd1);
        @(negedge clk);
        drive(1'b0, 16'h0000, 4'd15);
        check_all("rs4", 1'b1, 3'd4, 16'h0010, 1'b1, 4'hF, 16'h0000, 2'd1);
        @(negedge clk);

        // Randomized traffic against a queue model of issued groups.
        begin
            int m_state, m_pc, cyc, used, av, iss, gv, gc, gp, emask;
            logic rv;
            logic [15:0] rpc;
            logic [3:0] fr;
            grp_t g;
            do_reset();
            inflight.delete();
            m_state = 0;
            m_pc = 0;
            cyc = 0;
            for (int c = 0; c < 600; c++) begin
                rv  = ($urandom_range(0, 11) == 0);
                rpc = 16'($urandom);
                fr  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 4))
                                                   : 4'($urandom_range(5, 15));
                drive(rv, rpc, fr);

                used = 0;
                gv = 0; gc = 0; gp = 0;
                foreach (inflight[k]) begin
                    used += inflight[k].cnt;
                    if (inflight[k].born == cyc - 2) begin
                        gv = 1;
                        gc = inflight[k].cnt;
                        gp = inflight[k].pc;
                    end
                end
                av = int'(fr) - used;
                if (av < 0) av = 0;
                if (rv || m_state == 0) iss = 0;
                else iss = (av > 4) ? 4 : av;
                emask = gv ? (((1 << gc) - 1) << (4 - gc)) : 0;
                check_all($sformatf("rnd%0d", c), 1'(iss > 0), 3'(iss), 16'(m_pc),
                          1'(gv), 4'(emask), 16'(gp), 2'(m_state));

                if (rv) begin
                    inflight.delete();
                    m_pc = int'(rpc) & 32'hFFFE;
                    m_state = 3;
                end else begin
                    if (iss > 0) begin
                        g.cnt = iss; g.pc = m_pc; g.born = cyc;
                        inflight.push_back(g);
                    end
                    m_pc = (m_pc + 2 * iss) & 32'hFFFF;
                    m_state = (m_state == 0) ? 1 : ((iss == 0) ? 2 : 1);
                end
                while (inflight.size() > 0 && inflight[0].born <= cyc - 2) begin
                    void'(inflight.pop_front());
                end
                cyc++;
                @(negedge clk);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
